// File: rtl/glyph_row_sched.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// glyph_row_sched
//
// Shares one glyph ROM port among the 12 character slots of the RGB value
// overlay. Slot order: "R", R hundreds, R tens, R units, then the same four
// slots for G and for B. On each line_start the BCD digits and the glyph row
// are snapshotted, the front/back buffers are swapped, and the 12 glyph rows
// for the next line are fetched into the new back buffer. The pixel path
// reads the front buffer combinationally through rd_sel/rd_glyph.
//
// Optional feature (macro GLYPH_LEADING_ZERO_BLANK_EN):
//   leading-zero hundreds/tens slots are written as 16'h0000 in one cycle
//   with no ROM access. The units slot is never blanked.
//
// Parameters
//   ACK_TIMEOUT  cycles a slot may wait for rom_ack before it is zero-filled
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   line_start           1-cycle pulse at hblank start
//   row_addr             glyph row for the next line
//   R_*/G_*/B_* h,d,u    BCD digits of the three channel values
//   rom_req/code/row     request to the shared glyph ROM
//   rom_ack/rom_data     ROM response (data valid when rom_ack)
//   rd_sel/rd_glyph      front-buffer read port (0 for rd_sel > 11)
//   busy                 fetch in progress
//   done                 1-cycle pulse after the last slot is written
//   overrun              sticky: line_start arrived mid-fetch
//   timeout_err          sticky: a slot was zero-filled on timeout
// -----------------------------------------------------------------------------
module glyph_row_sched #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [3:0]  row_addr,
  input  logic [3:0]  R_h,
  input  logic [3:0]  R_d,
  input  logic [3:0]  R_u,
  input  logic [3:0]  G_h,
  input  logic [3:0]  G_d,
  input  logic [3:0]  G_u,
  input  logic [3:0]  B_h,
  input  logic [3:0]  B_d,
  input  logic [3:0]  B_u,
  output logic        rom_req,
  output logic [3:0]  rom_code,
  output logic [3:0]  rom_row,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  input  logic [3:0]  rd_sel,
  output logic [15:0] rd_glyph,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int SLOTS  = 12;
  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_FETCH
  } state_e;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] d;
    logic [3:0] u;
  } bcd_t;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  bcd_t               dig_q [3];
  bcd_t               dig_d [3];
  logic [3:0]         row_q, row_d;
  logic               front_sel_q, front_sel_d;
  logic [15:0]        buf_q [2][SLOTS];
  logic [15:0]        buf_d [2][SLOTS];
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  // Slot decode: idx[3:2] picks the channel, idx[1:0] the position in it.
  logic [1:0]  grp;
  logic [1:0]  pos;
  bcd_t        cur_dig;
  logic [3:0]  slot_code;
  logic        slot_blank;
  logic        fetching;
  logic        advance;
  logic [15:0] wr_data;

  assign grp      = idx_q[3:2];
  assign pos      = idx_q[1:0];
  assign fetching = (state_q == ST_FETCH);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_dig = dig_q[2];
    case (grp)
      2'd0:    cur_dig = dig_q[0];
      2'd1:    cur_dig = dig_q[1];
      default: cur_dig = dig_q[2];
    endcase
  end

  always_comb begin
    slot_code = cur_dig.u;
    case (pos)
      2'd0:    slot_code = 4'd10 + {2'b00, grp};  // 'R','G','B' label glyphs
      2'd1:    slot_code = cur_dig.h;
      2'd2:    slot_code = cur_dig.d;
      default: slot_code = cur_dig.u;
    endcase
  end

`ifdef GLYPH_LEADING_ZERO_BLANK_EN
  assign slot_blank = ((pos == 2'd1) && (cur_dig.h == 4'd0)) ||
                      ((pos == 2'd2) && (cur_dig.h == 4'd0) && (cur_dig.d == 4'd0));
`else
  assign slot_blank = 1'b0;
`endif

  assign rom_req     = fetching && !slot_blank;
  assign rom_code    = rom_req ? slot_code : 4'd0;
  assign rom_row     = rom_req ? row_q : 4'd0;
  assign busy        = fetching;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

  always_comb begin
    rd_glyph = 16'h0000;
    if (rd_sel < 4'(SLOTS)) rd_glyph = buf_q[front_sel_q][rd_sel];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    dig_d       = dig_q;
    row_d       = row_q;
    front_sel_d = front_sel_q;
    buf_d       = buf_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    advance     = 1'b0;
    wr_data     = 16'h0000;

    if (state_q == ST_FETCH) begin
      if (slot_blank) begin
        advance = 1'b1;
      end else if (rom_ack) begin
        advance = 1'b1;
        wr_data = rom_data;
      end else if (wait_q == WAIT_LAST) begin
        advance   = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end

      if (advance) begin
        buf_d[~front_sel_q][idx_q] = wr_data;
        wait_d = '0;
        if (idx_q == LAST_SLOT) begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
    end

    // The capture above lands before the swap, so a line_start that coincides
    // with the final slot swaps in a complete buffer and is not an overrun.
    if (line_start) begin
      if (state_d == ST_FETCH) overrun_d = 1'b1;
      front_sel_d = ~front_sel_q;
      dig_d[0]    = {R_h, R_d, R_u};
      dig_d[1]    = {G_h, G_d, G_u};
      dig_d[2]    = {B_h, B_d, B_u};
      row_d       = row_addr;
      idx_d       = 4'd0;
      wait_d      = '0;
      state_d     = ST_FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the glyph buffers are reset too, because the front buffer must read
  // as zero after reset (including a reset in the middle of a fetch).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      wait_q      <= '0;
      row_q       <= 4'd0;
      front_sel_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      for (int g = 0; g < 3; g++) dig_q[g] <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < SLOTS; s++) buf_q[b][s] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      row_q       <= row_d;
      front_sel_q <= front_sel_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      dig_q       <= dig_d;
      buf_q       <= buf_d;
    end
  end

endmodule
